// File: rtl/scheduler_request_arbiter_if.sv
// Bundle of requester, refill and scheduler signals around the request arbiter.
// The master side is the environment (cores and scheduler); the slave side is the arbiter.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif

interface scheduler_request_arbiter_if #(
   parameter int addrBits = `ADDRESS_BITS
) ();
   logic                core0ReqValid;
   logic                core0ReqReady;
   logic                core0ReqDeschedule;
   logic [addrBits-1:0] core0ReqDeschedulePid;
   logic                core0ReqSchedule;
   logic [addrBits-1:0] core0ReqSchedulePid;
   logic                core0Ack;

   logic                core1ReqValid;
   logic                core1ReqReady;
   logic                core1ReqDeschedule;
   logic [addrBits-1:0] core1ReqDeschedulePid;
   logic                core1ReqSchedule;
   logic [addrBits-1:0] core1ReqSchedulePid;
   logic                core1Ack;

   logic                refillRequest;
   logic                schedEnabled;
   logic                schedFinished;
   logic                hasDeschedule;
   logic [addrBits-1:0] deschedulePid;
   logic                hasSchedule;
   logic [addrBits-1:0] schedulePid;
   logic                busy;
   logic                timeoutError;

   modport master (
      output core0ReqValid, core0ReqDeschedule, core0ReqDeschedulePid,
             core0ReqSchedule, core0ReqSchedulePid,
      output core1ReqValid, core1ReqDeschedule, core1ReqDeschedulePid,
             core1ReqSchedule, core1ReqSchedulePid,
      output refillRequest, schedFinished,
      input  core0ReqReady, core0Ack, core1ReqReady, core1Ack,
      input  schedEnabled, hasDeschedule, deschedulePid, hasSchedule, schedulePid,
      input  busy, timeoutError
   );

   modport slave (
      input  core0ReqValid, core0ReqDeschedule, core0ReqDeschedulePid,
             core0ReqSchedule, core0ReqSchedulePid,
      input  core1ReqValid, core1ReqDeschedule, core1ReqDeschedulePid,
             core1ReqSchedule, core1ReqSchedulePid,
      input  refillRequest, schedFinished,
      output core0ReqReady, core0Ack, core1ReqReady, core1Ack,
      output schedEnabled, hasDeschedule, deschedulePid, hasSchedule, schedulePid,
      output busy, timeoutError
   );
endinterface

// File: rtl/scheduler_request_arbiter.sv
// Two-slot round-robin arbiter feeding schedule/deschedule requests to a scheduler,
// with an IDLE -> ISSUE -> GAP pass sequencer, plain refill passes and an issue timeout.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif

module scheduler_request_arbiter #(
   parameter int addrBits = `ADDRESS_BITS,
   parameter int TIMEOUT  = 1023
) (
   input logic                        clk,
   input logic                        reset,
   scheduler_request_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
   typedef enum logic [1:0] {OWN_CORE0, OWN_CORE1, OWN_REFILL} owner_t;

   typedef struct packed {
      logic                desched;
      logic [addrBits-1:0] desched_pid;
      logic                sched;
      logic [addrBits-1:0] sched_pid;
   } req_t;

   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   req_t        slot0_q, slot0_d;
   req_t        slot1_q, slot1_d;
   req_t        issue_q, issue_d;
   logic [1:0]  pending_q, pending_d;
   logic        rr_q, rr_d;          // 1: core1 has priority on the next contended grant
   logic [15:0] count_q, count_d;
   logic        timeout_err_q, timeout_err_d;
   logic        grant1;

   always_comb begin
      // NOTE: every value written here gets a default first, so no path can infer a latch.
      state_d       = state_q;
      owner_d       = owner_q;
      slot0_d       = slot0_q;
      slot1_d       = slot1_q;
      issue_d       = issue_q;
      pending_d     = pending_q;
      rr_d          = rr_q;
      count_d       = count_q;
      timeout_err_d = timeout_err_q;
      grant1        = pending_q[1] && (!pending_q[0] || rr_q);

      // Slot capture runs independently of the sequencer.
      if (bus.core0ReqValid && !pending_q[0]) begin
         slot0_d.desched     = bus.core0ReqDeschedule;
         slot0_d.desched_pid = bus.core0ReqDeschedulePid;
         slot0_d.sched       = bus.core0ReqSchedule;
         slot0_d.sched_pid   = bus.core0ReqSchedulePid;
         pending_d[0]        = 1'b1;
      end
      if (bus.core1ReqValid && !pending_q[1]) begin
         slot1_d.desched     = bus.core1ReqDeschedule;
         slot1_d.desched_pid = bus.core1ReqDeschedulePid;
         slot1_d.sched       = bus.core1ReqSchedule;
         slot1_d.sched_pid   = bus.core1ReqSchedulePid;
         pending_d[1]        = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pending_q != 2'b00) begin
               owner_d = grant1 ? OWN_CORE1 : OWN_CORE0;
               issue_d = grant1 ? slot1_q : slot0_q;
               rr_d    = !grant1;
               count_d = '0;
               state_d = ISSUE;
            end else if (bus.refillRequest) begin
               owner_d = OWN_REFILL;
               issue_d = '0;
               count_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.schedFinished || (count_q + 16'd1 == TIMEOUT_C)) begin
               // Finish takes precedence over a timeout landing in the same cycle.
               if (!bus.schedFinished) timeout_err_d = 1'b1;
               if (owner_q == OWN_CORE0) pending_d[0] = 1'b0;
               if (owner_q == OWN_CORE1) pending_d[1] = 1'b0;
               state_d = GAP;
            end else begin
               count_d = count_q + 16'd1;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         owner_q       <= OWN_REFILL;
         slot0_q       <= '0;
         slot1_q       <= '0;
         issue_q       <= '0;
         pending_q     <= '0;
         rr_q          <= 1'b0;
         count_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         slot0_q       <= slot0_d;
         slot1_q       <= slot1_d;
         issue_q       <= issue_d;
         pending_q     <= pending_d;
         rr_q          <= rr_d;
         count_q       <= count_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Enables and acks decode straight from the state so reset drops them without a clock.
   assign bus.core0ReqReady = !pending_q[0];
   assign bus.core1ReqReady = !pending_q[1];
   assign bus.core0Ack      = (state_q == GAP) && (owner_q == OWN_CORE0);
   assign bus.core1Ack      = (state_q == GAP) && (owner_q == OWN_CORE1);
   assign bus.schedEnabled  = (state_q == ISSUE);
   assign bus.busy          = (state_q != IDLE);
   assign bus.hasDeschedule = issue_q.desched;
   assign bus.deschedulePid = issue_q.desched_pid;
   assign bus.hasSchedule   = issue_q.sched;
   assign bus.schedulePid   = issue_q.sched_pid;
   assign bus.timeoutError  = timeout_err_q;
endmodule

// File: tb/tb_scheduler_request_arbiter.sv
// Directed bench for scheduler_request_arbiter: single pass, contention, refill ordering,
// timeout and its finish-wins boundary, combined requests and reset during ISSUE.
module tb_scheduler_request_arbiter;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   scheduler_request_arbiter_if #(.addrBits(8)) bus ();

   scheduler_request_arbiter #(.addrBits(8), .TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.core0ReqValid = 0; bus.core0ReqDeschedule = 0; bus.core0ReqDeschedulePid = 0;
      bus.core0ReqSchedule = 0; bus.core0ReqSchedulePid = 0;
      bus.core1ReqValid = 0; bus.core1ReqDeschedule = 0; bus.core1ReqDeschedulePid = 0;
      bus.core1ReqSchedule = 0; bus.core1ReqSchedulePid = 0;
      bus.refillRequest = 0; bus.schedFinished = 0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_sen"},   bus.schedEnabled, 0);
      check({tag, "_busy"},  bus.busy, 0);
      check({tag, "_rdy0"},  bus.core0ReqReady, 1);
      check({tag, "_rdy1"},  bus.core1ReqReady, 1);
      check({tag, "_ack0"},  bus.core0Ack, 0);
      check({tag, "_ack1"},  bus.core1Ack, 0);
      check({tag, "_hd"},    bus.hasDeschedule, 0);
      check({tag, "_hs"},    bus.hasSchedule, 0);
      check({tag, "_dpid"},  bus.deschedulePid, 0);
      check({tag, "_spid"},  bus.schedulePid, 0);
      check({tag, "_terr"},  bus.timeoutError, 0);
   endtask

   task automatic apply_reset(input string tag);
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle(tag);
      reset = 1'b1;
      tick();
   endtask

   task automatic drive_req(input int core, input logic hd, input logic [7:0] dp,
                            input logic hs, input logic [7:0] sp);
      if (core == 0) begin
         bus.core0ReqValid = 1; bus.core0ReqDeschedule = hd; bus.core0ReqDeschedulePid = dp;
         bus.core0ReqSchedule = hs; bus.core0ReqSchedulePid = sp;
      end else begin
         bus.core1ReqValid = 1; bus.core1ReqDeschedule = hd; bus.core1ReqDeschedulePid = dp;
         bus.core1ReqSchedule = hs; bus.core1ReqSchedulePid = sp;
      end
   endtask

   // Waits one cycle into ISSUE, checks the presented request for hold+1 cycles, then
   // finishes it; returns positioned in GAP with the ack checked (ack_who 2 = nobody).
   task automatic do_pass(input string tag, input logic hd, input logic [7:0] dp,
                          input logic hs, input logic [7:0] sp, input int ack_who,
                          input int hold);
      int n;
      n = 0;
      while (!bus.schedEnabled && n < 6) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, 1);
      for (int i = 0; i <= hold; i++) begin
         check({tag, "_sen"},  bus.schedEnabled, 1);
         check({tag, "_busy"}, bus.busy, 1);
         check({tag, "_hd"},   bus.hasDeschedule, hd);
         check({tag, "_dpid"}, bus.deschedulePid, dp);
         check({tag, "_hs"},   bus.hasSchedule, hs);
         check({tag, "_spid"}, bus.schedulePid, sp);
         if (i < hold) tick();
      end
      bus.schedFinished = 1;
      tick();
      bus.schedFinished = 0;
      check({tag, "_gap_sen"},  bus.schedEnabled, 0);
      check({tag, "_gap_busy"}, bus.busy, 1);
      check({tag, "_ack0"},     bus.core0Ack, (ack_who == 0));
      check({tag, "_ack1"},     bus.core1Ack, (ack_who == 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int cycles;
      n_cmp = 0;
      n_bad = 0;
      clear_inputs();

      // Single request from core0, schedule PID 5.
      apply_reset("rst0");
      drive_req(0, 0, 0, 1, 5);
      tick();
      clear_inputs();
      check("single_rdy0_low", bus.core0ReqReady, 0);
      check("single_idle_sen", bus.schedEnabled, 0);
      do_pass("single", 0, 0, 1, 5, 0, 0);
      check("single_gap_rdy0", bus.core0ReqReady, 1);
      tick();
      check("single_done_busy", bus.busy, 0);
      check("single_done_ack0", bus.core0Ack, 0);

      // Contention: core0 (3) wins first after reset, core0 re-requests in GAP, core1 (7) wins next.
      apply_reset("rst1");
      drive_req(0, 0, 0, 1, 3);
      drive_req(1, 0, 0, 1, 7);
      tick();
      clear_inputs();
      do_pass("cont_a", 0, 0, 1, 3, 0, 0);
      check("cont_a_rdy1", bus.core1ReqReady, 0);
      drive_req(0, 0, 0, 1, 4);
      tick();
      clear_inputs();
      check("cont_idle_busy", bus.busy, 0);
      check("cont_rdy0_low", bus.core0ReqReady, 0);
      do_pass("cont_b", 0, 0, 1, 7, 1, 0);
      tick();
      do_pass("cont_c", 0, 0, 1, 4, 0, 0);
      tick();

      // Refill yields to a pending core1 slot and acks nobody.
      apply_reset("rst2");
      drive_req(1, 0, 0, 1, 6);
      tick();
      clear_inputs();
      bus.refillRequest = 1;
      do_pass("refill_c1", 0, 0, 1, 6, 1, 0);
      tick();
      check("refill_idle_busy", bus.busy, 0);
      do_pass("refill", 0, 0, 0, 0, 2, 1);
      bus.refillRequest = 0;
      tick();
      tick();
      check("refill_off_busy", bus.busy, 0);
      check("refill_off_sen",  bus.schedEnabled, 0);

      // Flagless core0 request; core1 accepted mid-ISSUE, then a desched+sched pass.
      drive_req(0, 0, 0, 0, 0);
      tick();
      clear_inputs();
      tick();
      check("empty_sen", bus.schedEnabled, 1);
      check("empty_hs",  bus.hasSchedule, 0);
      check("empty_hd",  bus.hasDeschedule, 0);
      drive_req(1, 1, 2, 1, 9);
      tick();
      clear_inputs();
      check("midissue_rdy1", bus.core1ReqReady, 0);
      check("midissue_sen",  bus.schedEnabled, 1);
      bus.schedFinished = 1;
      tick();
      bus.schedFinished = 0;
      check("empty_ack0", bus.core0Ack, 1);
      check("empty_ack1", bus.core1Ack, 0);
      tick();
      do_pass("both", 1, 2, 1, 9, 1, 3);
      tick();

      // Timeout with TIMEOUT=8: exactly 8 ISSUE cycles, sticky error, normal ack.
      apply_reset("rst3");
      drive_req(0, 0, 0, 1, 1);
      tick();
      clear_inputs();
      tick();
      cycles = 0;
      while (bus.schedEnabled && cycles < 20) begin
         cycles++;
         tick();
      end
      check("to_cycles", cycles, 8);
      check("to_ack0",   bus.core0Ack, 1);
      check("to_err",    bus.timeoutError, 1);
      tick();
      check("to_idle_busy", bus.busy, 0);
      drive_req(1, 0, 0, 1, 10);
      tick();
      clear_inputs();
      do_pass("to_next", 0, 0, 1, 10, 1, 0);
      check("to_err_sticky", bus.timeoutError, 1);
      tick();

      // Finish arriving in the cycle the counter reaches TIMEOUT wins: no error.
      apply_reset("rst4");
      drive_req(0, 0, 0, 1, 11);
      tick();
      clear_inputs();
      do_pass("fin_wins", 0, 0, 1, 11, 0, 7);
      check("fin_wins_err", bus.timeoutError, 0);
      tick();

      // Reset during ISSUE drops everything at once and no ack follows.
      drive_req(0, 0, 0, 1, 12);
      drive_req(1, 0, 0, 1, 13);
      tick();
      clear_inputs();
      tick();
      check("rmid_sen_before", bus.schedEnabled, 1);
      reset = 1'b0;
      #1;
      check("rmid_sen",  bus.schedEnabled, 0);
      check("rmid_rdy0", bus.core0ReqReady, 1);
      check("rmid_rdy1", bus.core1ReqReady, 1);
      check("rmid_busy", bus.busy, 0);
      #3;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rmid_post_ack0", bus.core0Ack, 0);
         check("rmid_post_ack1", bus.core1Ack, 0);
         check("rmid_post_busy", bus.busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
